// File: rtl/aes_pkg.sv
// Shared AES definitions for the inverse cipher core.
// Holds the round-constant table, GF(2^8) helpers, forward/inverse S-box functions,
// the InvMixColumns column function and the controller state enum.
// S-boxes are computed as field inversion plus affine map instead of stored tables.
package aes_pkg;

    typedef enum logic [1:0] {StIdle, StKexp, StRound, StDone} aes_state_e;

    // Index 0 is unused; Rcon[1..10] feed key-schedule steps 1..10.
    localparam logic [7:0] RCON [0:10] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                           8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    // Out-of-range indices (counter wrap after the last round) read as zero.
    function automatic logic [7:0] rcon(input logic [3:0] idx);
        if (idx > 4'd10) begin
            return 8'h00;
        end
        return RCON[idx];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ x;
            end
            x = xtime(x);
        end
        return acc;
    endfunction

    // a^254 == a^-1 in GF(2^8); maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] res;
        logic [7:0] sq;
        res = 8'h01;
        sq  = a;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            res = gf_mul(res, sq);
        end
        return res;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] v;
        v = gf_inv(a);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]}
            ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] t;
        t = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Column bytes: [31:24] is row 0 ... [7:0] is row 3.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gf_mul(8'h0e, a0) ^ gf_mul(8'h0b, a1) ^ gf_mul(8'h0d, a2) ^ gf_mul(8'h09, a3),
                gf_mul(8'h09, a0) ^ gf_mul(8'h0e, a1) ^ gf_mul(8'h0b, a2) ^ gf_mul(8'h0d, a3),
                gf_mul(8'h0d, a0) ^ gf_mul(8'h09, a1) ^ gf_mul(8'h0e, a2) ^ gf_mul(8'h0b, a3),
                gf_mul(8'h0b, a0) ^ gf_mul(8'h0d, a1) ^ gf_mul(8'h09, a2) ^ gf_mul(8'h0e, a3)};
    endfunction

endpackage

// File: rtl/aes_inv_cipher_core_if.sv
// Handshake bundle for the AES inverse cipher core.
// Input side: in_valid/in_ready with in_data (ciphertext) and in_key.
// Output side: out_valid/out_ready with out_data (plaintext), plus busy status.
// master = producer/consumer side (testbench, link layer); slave = the core.
interface aes_inv_cipher_core_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    modport master (
        output in_valid, in_data, in_key, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_key, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round:
// InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns.
// Ports: state_i (128-bit state, byte 0 in [127:120], column-major), rk_i (round key),
//        last_round_i (skip InvMixColumns), state_o (round result).
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] rk_i,
    input  logic         last_round_i,
    output logic [127:0] state_o
);

    logic [127:0] sub;
    logic [127:0] ark;
    logic [127:0] mix;

    // Byte index is 4*col + row; row r is rotated right by r columns.
    always_comb begin
        sub = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sub[127 - 8 * (4 * c + r) -: 8] =
                    inv_sbox(state_i[127 - 8 * (4 * ((c + 4 - r) % 4) + r) -: 8]);
            end
        end
    end

    assign ark = sub ^ rk_i;

    always_comb begin
        mix = '0;
        for (int c = 0; c < 4; c++) begin
            mix[127 - 32 * c -: 32] = inv_mix_col(ark[127 - 32 * c -: 32]);
        end
    end

    assign state_o = last_round_i ? ark : mix;

endmodule

// File: rtl/aes_inv_cipher_core.sv
// Iterative AES-128 decryption core, one inverse round per clock.
// Round keys are generated on the fly: forward schedule up to K10, then the schedule is
// run backwards alongside the inverse rounds. With KEY_REUSE the last key and its K10
// are cached so a repeated key skips the forward expansion.
// Ports: clk, rst_n (synchronous, active low), bus_io (slave side of the handshake bundle).
module aes_inv_cipher_core
    import aes_pkg::*;
#(
    parameter bit KEY_REUSE = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    aes_inv_cipher_core_if.slave        bus_io
);

    aes_state_e   st_q, st_d;
    logic [127:0] state_q, state_d;
    logic [127:0] rk_q, rk_d;
    logic [3:0]   rcnt_q, rcnt_d;
    logic [127:0] out_q, out_d;
    logic [127:0] ckey_q, ckey_d;
    logic [127:0] ck10_q, ck10_d;
    logic         cvld_q, cvld_d;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  fw0, fw1, fw2, fw3;
    logic [31:0]  iw0, iw1, iw2, iw3;
    logic [127:0] rk_fwd, rk_inv;
    logic [7:0]   rc_fwd, rc_inv;
    logic [127:0] round_out;
    logic         last_round;
    logic         cache_hit;

    assign {w0, w1, w2, w3} = rk_q;

    // Forward step uses Rcon[rcnt]; the inverse step undoes step rcnt+1.
    assign rc_fwd = rcon(rcnt_q);
    assign rc_inv = rcon(rcnt_q + 4'd1);

    assign fw0    = w0 ^ sub_word(rot_word(w3)) ^ {rc_fwd, 24'h0};
    assign fw1    = w1 ^ fw0;
    assign fw2    = w2 ^ fw1;
    assign fw3    = w3 ^ fw2;
    assign rk_fwd = {fw0, fw1, fw2, fw3};

    assign iw3    = w3 ^ w2;
    assign iw2    = w2 ^ w1;
    assign iw1    = w1 ^ w0;
    assign iw0    = w0 ^ sub_word(rot_word(iw3)) ^ {rc_inv, 24'h0};
    assign rk_inv = {iw0, iw1, iw2, iw3};

    assign last_round = (rcnt_q == 4'd0);

    aes_inv_round u_round (
        .state_i      (state_q),
        .rk_i         (rk_inv),
        .last_round_i (last_round),
        .state_o      (round_out)
    );

    assign cache_hit = KEY_REUSE && cvld_q && (bus_io.in_key == ckey_q);

    always_comb begin
        st_d    = st_q;
        state_d = state_q;
        rk_d    = rk_q;
        rcnt_d  = rcnt_q;
        out_d   = out_q;
        ckey_d  = ckey_q;
        ck10_d  = ck10_q;
        cvld_d  = cvld_q;
        unique case (st_q)
            StIdle: begin
                if (bus_io.in_valid) begin
                    if (cache_hit) begin
                        state_d = bus_io.in_data ^ ck10_q;
                        rk_d    = ck10_q;
                        rcnt_d  = 4'd9;
                        st_d    = StRound;
                    end else begin
                        state_d = bus_io.in_data;
                        rk_d    = bus_io.in_key;
                        rcnt_d  = 4'd1;
                        st_d    = StKexp;
                        // Cache stays invalid until K10 for this key exists.
                        if (KEY_REUSE) begin
                            ckey_d = bus_io.in_key;
                            cvld_d = 1'b0;
                        end
                    end
                end
            end
            StKexp: begin
                rk_d   = rk_fwd;
                rcnt_d = rcnt_q + 4'd1;
                if (rcnt_q == 4'd10) begin
                    state_d = state_q ^ rk_fwd;
                    rcnt_d  = 4'd9;
                    st_d    = StRound;
                    if (KEY_REUSE) begin
                        ck10_d = rk_fwd;
                        cvld_d = 1'b1;
                    end
                end
            end
            StRound: begin
                rk_d   = rk_inv;
                rcnt_d = rcnt_q - 4'd1;
                if (last_round) begin
                    out_d = round_out;
                    st_d  = StDone;
                end else begin
                    state_d = round_out;
                end
            end
            StDone: begin
                if (bus_io.out_ready) begin
                    st_d = StIdle;
                end
            end
            default: st_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q    <= StIdle;
            state_q <= '0;
            rk_q    <= '0;
            rcnt_q  <= '0;
            out_q   <= '0;
            ckey_q  <= '0;
            ck10_q  <= '0;
            cvld_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            state_q <= state_d;
            rk_q    <= rk_d;
            rcnt_q  <= rcnt_d;
            out_q   <= out_d;
            ckey_q  <= ckey_d;
            ck10_q  <= ck10_d;
            cvld_q  <= cvld_d;
        end
    end

    assign bus_io.in_ready  = (st_q == StIdle);
    assign bus_io.out_valid = (st_q == StDone);
    assign bus_io.busy      = (st_q == StKexp) || (st_q == StRound);
    assign bus_io.out_data  = out_q;

endmodule

// File: tb/tb_aes_inv_cipher_core.sv
// Scoreboard bench for aes_inv_cipher_core: the driver pushes expected plaintext and
// latency per accepted block; the monitor pops and compares when out_valid appears.
module tb_aes_inv_cipher_core;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   n_sent = 0;
    int   n_recv = 0;
    int   stall_n = -1;

    typedef struct {
        logic [127:0] pt;
        int           tx;
        int           lat;
    } exp_t;
    exp_t q[$];

    logic [7:0]   sb  [256];
    logic [7:0]   isb [256];
    logic [127:0] ckey_m;
    logic         cvld_m = 1'b0;

    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

    aes_inv_cipher_core_if bus ();

    aes_inv_cipher_core #(
        .KEY_REUSE (1'b1)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = xt(x);
        end
        return acc;
    endfunction

    // S-box via walking the multiplicative group with generator 3 and its inverse.
    task automatic build_tables();
        logic [7:0] p, qq, x;
        p  = 8'h01;
        qq = 8'h01;
        do begin
            p  = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            qq = qq ^ {qq[6:0], 1'b0};
            qq = qq ^ {qq[5:0], 2'b00};
            qq = qq ^ {qq[3:0], 4'h0};
            if (qq[7]) qq = qq ^ 8'h09;
            x = qq ^ rotl8(qq, 1) ^ rotl8(qq, 2) ^ rotl8(qq, 3) ^ rotl8(qq, 4);
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
        for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
    endtask

    // Textbook AES-128 decryption on a 4x4 byte matrix s[row][col].
    function automatic logic [127:0] ref_decrypt(input logic [127:0] key, input logic [127:0] ct);
        logic [31:0]  w  [44];
        logic [127:0] rk [11];
        logic [7:0]   s  [4][4];
        logic [7:0]   t  [4][4];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i - 1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
                rc  = xt(rc);
            end
            w[i] = w[i - 4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = ct[127 - 8 * (4 * c + r) -: 8] ^ rk[10][127 - 8 * (4 * c + r) -: 8];
        for (int rd = 9; rd >= 0; rd--) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[r][c] = isb[s[r][(c + 4 - r) % 4]] ^ rk[rd][127 - 8 * (4 * c + r) -: 8];
            for (int c = 0; c < 4; c++) begin
                if (rd > 0) begin
                    s[0][c] = mul(8'h0e, t[0][c]) ^ mul(8'h0b, t[1][c]) ^ mul(8'h0d, t[2][c]) ^ mul(8'h09, t[3][c]);
                    s[1][c] = mul(8'h09, t[0][c]) ^ mul(8'h0e, t[1][c]) ^ mul(8'h0b, t[2][c]) ^ mul(8'h0d, t[3][c]);
                    s[2][c] = mul(8'h0d, t[0][c]) ^ mul(8'h09, t[1][c]) ^ mul(8'h0e, t[2][c]) ^ mul(8'h0b, t[3][c]);
                    s[3][c] = mul(8'h0b, t[0][c]) ^ mul(8'h0d, t[1][c]) ^ mul(8'h09, t[2][c]) ^ mul(8'h0e, t[3][c]);
                end else begin
                    for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
                end
            end
        end
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) res[127 - 8 * (4 * c + r) -: 8] = s[r][c];
        return res;
    endfunction

    // Called at a negedge; holds in_valid until the core is ready, records the transfer.
    task automatic send(input logic [127:0] key, input logic [127:0] ct,
                        input logic [127:0] exp_pt, output int tx);
        int   n;
        exp_t e;
        logic hit;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_key   = key;
        bus.in_data  = ct;
        while (bus.in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready got %b, expected 1 within 200 cycles", bus.in_ready);
            bus.in_valid = 1'b0;
            tx = -1;
            return;
        end
        tx    = cyc + 1;
        hit   = cvld_m && (key == ckey_m);
        e.pt  = exp_pt;
        e.tx  = tx;
        e.lat = hit ? 10 : 20;
        if (!hit) begin
            ckey_m = key;
            cvld_m = 1'b1;
        end
        q.push_back(e);
        n_sent++;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = rnd128();
        bus.in_key   = rnd128();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || bus.out_valid === 1'b1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", q.size());
        end
        @(negedge clk);
    endtask

    initial begin : monitor
        bit           seen;
        int           stall_left;
        logic [127:0] held;
        exp_t         e;
        seen          = 1'b0;
        stall_left    = 0;
        held          = '0;
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                if (!seen) begin
                    seen = 1'b1;
                    held = bus.out_data;
                    n_recv++;
                    if (q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_output: got %h, expected no output", bus.out_data);
                    end else begin
                        e = q.pop_front();
                        check("plaintext", bus.out_data, e.pt);
                        check("latency", 128'(cyc - e.tx), 128'(e.lat));
                    end
                    if (stall_n >= 0) begin
                        stall_left = stall_n;
                        stall_n    = -1;
                    end else begin
                        stall_left = $urandom_range(0, 3);
                    end
                end else begin
                    check("out_data_hold", bus.out_data, held);
                end
                check("in_ready_in_done", 128'(bus.in_ready), 128'(1'b0));
                if (stall_left == 0) begin
                    bus.out_ready = 1'b1;
                end else begin
                    bus.out_ready = 1'b0;
                    stall_left--;
                end
            end else begin
                seen          = 1'b0;
                bus.out_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int           tx;
        int           n;
        logic [127:0] key;
        logic [127:0] ct;
        build_tables();
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_key   = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 128'(bus.in_ready), 128'(1'b1));
        check("rst_out_valid", 128'(bus.out_valid), 128'(1'b0));
        check("rst_busy", 128'(bus.busy), 128'(1'b0));
        check("rst_out_data", bus.out_data, 128'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Known-answer blocks, then a cache hit with the App B key.
        send(KEY_C, CT_C, PT_C, tx);
        drain();
        send(KEY_B, CT_B, PT_B, tx);
        drain();
        send(KEY_B, CT_C, ref_decrypt(KEY_B, CT_C), tx);
        drain();

        // Back-pressure with in_valid pulses while the result is held.
        stall_n = 15;
        send(KEY_C, CT_C, PT_C, tx);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data  = rnd128();
            bus.in_key   = rnd128();
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        drain();

        // Alternating keys always miss the single-entry cache.
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) send(KEY_B, CT_B, PT_B, tx);
            else            send(KEY_C, CT_C, PT_C, tx);
        end
        drain();

        // Reset during ROUND with rcnt=5, after this key has been cached.
        send(KEY_B, CT_B, PT_B, tx);
        repeat (14) @(negedge clk);
        check("busy_in_round", 128'(bus.busy), 128'(1'b1));
        rst_n = 1'b0;
        n_sent -= q.size();
        q.delete();
        cvld_m = 1'b0;
        @(negedge clk);
        check("abort_in_ready", 128'(bus.in_ready), 128'(1'b1));
        check("abort_out_valid", 128'(bus.out_valid), 128'(1'b0));
        check("abort_busy", 128'(bus.busy), 128'(1'b0));
        check("abort_out_data", bus.out_data, 128'h0);
        rst_n = 1'b1;
        @(negedge clk);
        send(KEY_B, CT_B, PT_B, tx);
        drain();

        // Randomized blocks with key reuse, gaps and output stalls.
        key = KEY_B;
        for (int b = 0; b < 1000; b++) begin
            case ($urandom_range(0, 3))
                0:       key = key;
                1:       key = KEY_C;
                default: key = rnd128();
            endcase
            ct = rnd128();
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(key, ct, ref_decrypt(key, ct), tx);
        end
        drain();

        check("block_count", 128'(n_recv), 128'(n_sent));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
